// File: rtl/at89c2051_dut_model.sv
// Behavioural target-side model of the AT89C2051 flash programming interface.
// Decodes the P3.x mode pins and RST/VPP level, runs the internal address
// counter, byte write, chip erase and RDY/BSY handshake against an internal
// array. The array and lock bit are non-volatile: rst_n does not touch them.
module at89c2051_dut_model #(
  parameter int         MEM_BYTES        = 2048,
  parameter int         WRITE_CYCLES     = 24000,
  parameter int         ERASE_MIN_CYCLES = 240000,
  parameter logic [7:0] SIG0             = 8'h1E,
  parameter logic [7:0] SIG1             = 8'h21
) (
  input  logic       osc,
  input  logic       rst_n,
  input  logic [1:0] rst_level,
  input  logic       xtal1,
  input  logic       prog_n,
  input  logic       p33,
  input  logic       p34,
  input  logic       p35,
  input  logic       p37,
  input  logic [7:0] p1_in,
  output logic [7:0] p1_out,
  output logic       p1_oe,
  output logic       rdy,
  output logic       lock1
);

  localparam int              AW         = $clog2(MEM_BYTES);
  localparam logic [AW-1:0]   ADDR_LAST  = AW'(MEM_BYTES - 1);
  localparam logic [17:0]     WR_LOAD    = 18'(WRITE_CYCLES);
  localparam logic [17:0]     ER_LAST    = 18'(ERASE_MIN_CYCLES - 1);
  localparam logic [17:0]     SWEEP_LAST = 18'(MEM_BYTES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WR_BUSY, ST_ER_HOLD, ST_ER_SWEEP} state_t;
  typedef enum logic [2:0] {MD_NONE, MD_WRITE, MD_READ, MD_ERASE, MD_SIGREAD, MD_LOCKW} mode_t;

  // Mode decode from {p37,p35,p34,p33} and the RST/VPP level (bit 1 set = 12 V).
  function automatic mode_t decode_mode(input logic [3:0] pins, input logic [1:0] lvl);
    mode_t m;
    m = MD_NONE;
    case (pins)
      4'b1110: m = lvl[1] ? MD_WRITE : MD_NONE;
      4'b1100: m = (lvl != 2'd0) ? MD_READ : MD_NONE;
      4'b0001: m = lvl[1] ? MD_ERASE : MD_NONE;
      4'b0000: m = (lvl != 2'd0) ? MD_SIGREAD : MD_NONE;
      4'b1111: m = lvl[1] ? MD_LOCKW : MD_NONE;
      default: m = MD_NONE;
    endcase
    return m;
  endfunction

  // Array is held inverted so the power-up all-zero register state reads as
  // erased (8'hFF); a flash write can then only set stored bits.
  logic [7:0]    mem_inv [MEM_BYTES];
  logic          lock1_r;

  logic [15:0]   pins_s;
  logic [15:0]   sync1_r;
  logic [15:0]   sync2_r;
  logic          xtal_d_r;
  logic          prog_d_r;
  logic [1:0]    lvl_s;
  logic          xtal_s;
  logic          prog_s;
  logic [3:0]    mode_pins_s;
  logic [7:0]    p1_s;
  logic          xtal_rise_s;
  logic          prog_fall_s;
  mode_t         mode_s;

  state_t        state_r;
  state_t        state_nx_s;
  logic [17:0]   timer_r;
  logic [17:0]   timer_nx_s;
  logic [AW-1:0] addr_r;
  logic          rdy_r;
  logic [7:0]    p1_out_r;
  logic          p1_oe_r;

  logic          mem_we_s;
  logic [AW-1:0] mem_idx_s;
  logic [7:0]    mem_wdata_s;
  logic          lock_set_s;
  logic          lock_clr_s;

  assign pins_s      = {rst_level, xtal1, prog_n, p37, p35, p34, p33, p1_in};
  assign lvl_s       = sync2_r[15:14];
  assign xtal_s      = sync2_r[13];
  assign prog_s      = sync2_r[12];
  assign mode_pins_s = sync2_r[11:8];
  assign p1_s        = sync2_r[7:0];
  assign xtal_rise_s = xtal_s & ~xtal_d_r;
  assign prog_fall_s = ~prog_s & prog_d_r;

  // Two-flop synchronisers on every pin plus the edge-detect history bits.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 16'h0000;
      sync2_r  <= 16'h0000;
      xtal_d_r <= 1'b0;
      prog_d_r <= 1'b0;
    end else begin
      sync1_r  <= pins_s;
      sync2_r  <= sync1_r;
      xtal_d_r <= xtal_s;
      prog_d_r <= prog_s;
    end
  end

  // Decode the current programming mode from synchronised pins.
  always_comb begin
    mode_s = decode_mode(mode_pins_s, lvl_s);
  end

  // FSM state and shared timer/sweep-index register.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      timer_r <= 18'd0;
    end else begin
      state_r <= state_nx_s;
      timer_r <= timer_nx_s;
    end
  end

  // Next-state logic, array write strobe and lock bit control.
  always_comb begin
    state_nx_s  = state_r;
    timer_nx_s  = timer_r;
    mem_we_s    = 1'b0;
    mem_idx_s   = addr_r;
    mem_wdata_s = mem_inv[addr_r] | ~p1_s;
    lock_set_s  = 1'b0;
    lock_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (prog_fall_s && (mode_s == MD_WRITE)) begin
          // A locked device still reports busy but leaves the array alone.
          mem_we_s   = ~lock1_r;
          state_nx_s = ST_WR_BUSY;
          timer_nx_s = WR_LOAD;
        end else if (prog_fall_s && (mode_s == MD_LOCKW)) begin
          lock_set_s = 1'b1;
          state_nx_s = ST_WR_BUSY;
          timer_nx_s = WR_LOAD;
        end else if (prog_fall_s && (mode_s == MD_ERASE)) begin
          state_nx_s = ST_ER_HOLD;
          timer_nx_s = 18'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WR_BUSY: begin
        if (timer_r <= 18'd1) begin
          state_nx_s = ST_IDLE;
          timer_nx_s = 18'd0;
        end else begin
          timer_nx_s = timer_r - 18'd1;
        end
      end
      ST_ER_HOLD: begin
        if (prog_s || (mode_s != MD_ERASE)) begin
          state_nx_s = ST_IDLE;
          timer_nx_s = 18'd0;
        end else if (timer_r == ER_LAST) begin
          state_nx_s = ST_ER_SWEEP;
          timer_nx_s = 18'd0;
        end else begin
          timer_nx_s = timer_r + 18'd1;
        end
      end
      ST_ER_SWEEP: begin
        mem_we_s    = 1'b1;
        mem_idx_s   = timer_r[AW-1:0];
        mem_wdata_s = 8'h00;
        if (timer_r == SWEEP_LAST) begin
          lock_clr_s = 1'b1;
          state_nx_s = ST_IDLE;
          timer_nx_s = 18'd0;
        end else begin
          timer_nx_s = timer_r + 18'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        timer_nx_s = 18'd0;
      end
    endcase
  end

  // Non-volatile array: written by byte programming and the erase sweep only.
  always_ff @(posedge osc) begin
    if (mem_we_s) begin
      mem_inv[mem_idx_s] <= mem_wdata_s;
    end
  end

  // Non-volatile lock bit: set by LOCKW, cleared at the end of a chip erase.
  always_ff @(posedge osc) begin
    if (lock_set_s) begin
      lock1_r <= 1'b1;
    end else if (lock_clr_s) begin
      lock1_r <= 1'b0;
    end
  end

  // Address counter: cleared at RST low, advanced by XTAL1 only when ready.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
    end else if (lvl_s == 2'd0) begin
      addr_r <= '0;
    end else if (xtal_rise_s && rdy_r) begin
      addr_r <= (addr_r == ADDR_LAST) ? '0 : addr_r + AW'(1);
    end
  end

  // RDY/BSY pin, low while a byte write or the erase sweep is running.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r <= 1'b1;
    end else begin
      rdy_r <= ~((state_r == ST_WR_BUSY) || (state_r == ST_ER_SWEEP));
    end
  end

  // Registered P1 read data and output enable.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      p1_out_r <= 8'h00;
      p1_oe_r  <= 1'b0;
    end else begin
      p1_oe_r <= ((mode_s == MD_READ) || (mode_s == MD_SIGREAD)) && (state_r == ST_IDLE);
      case (mode_s)
        MD_READ:    p1_out_r <= lock1_r ? 8'hFF : ~mem_inv[addr_r];
        MD_SIGREAD: p1_out_r <= (addr_r == '0) ? SIG0 :
                                (addr_r == AW'(1)) ? SIG1 : 8'hFF;
        default:    p1_out_r <= 8'h00;
      endcase
    end
  end

  assign p1_out = p1_out_r;
  assign p1_oe  = p1_oe_r;
  assign rdy    = rdy_r;
  assign lock1  = lock1_r;

endmodule

// File: tb/tb_at89c2051_dut_model.sv
// Self-checking bench for at89c2051_dut_model, using shortened timing
// parameters. Expected P1 reads come from a bench-side memory/address model
// and flow through a scoreboard queue.
module tb_at89c2051_dut_model;

  localparam int MB = 256;
  localparam int WC = 300;
  localparam int EM = 3000;

  logic       osc;
  logic       rst_n;
  logic [1:0] rst_level;
  logic       xtal1;
  logic       prog_n;
  logic       p33, p34, p35, p37;
  logic [7:0] p1_in;
  logic [7:0] p1_out;
  logic       p1_oe;
  logic       rdy;
  logic       lock1;

  int         total;
  int         bad;
  logic [7:0] mem_m [MB];
  int         addr_m;
  logic       lock_m;
  logic [1:0] cur_lvl;
  logic [3:0] cur_m;
  logic [8:0] exp_q [$];
  logic [8:0] want;
  logic [8:0] got;

  at89c2051_dut_model #(
    .MEM_BYTES(MB), .WRITE_CYCLES(WC), .ERASE_MIN_CYCLES(EM),
    .SIG0(8'h1E), .SIG1(8'h21)
  ) dut (
    .osc(osc), .rst_n(rst_n), .rst_level(rst_level), .xtal1(xtal1),
    .prog_n(prog_n), .p33(p33), .p34(p34), .p35(p35), .p37(p37),
    .p1_in(p1_in), .p1_out(p1_out), .p1_oe(p1_oe), .rdy(rdy), .lock1(lock1)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  initial begin
    #5000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge osc);
  endtask

  task automatic set_pins(input logic [1:0] lvl, input logic [3:0] m);
    rst_level = lvl;
    {p37, p35, p34, p33} = m;
    cur_lvl = lvl;
    cur_m = m;
    if (lvl == 2'd0) addr_m = 0;
    tick(6);
  endtask

  task automatic pulse_x();
    if (cur_lvl != 2'd0) addr_m = (addr_m + 1) % MB;
    xtal1 = 1'b1;
    tick(4);
    xtal1 = 1'b0;
    tick(4);
  endtask

  // Expected {p1_oe, p1_out} for the current READ / SIGREAD pin setup.
  function automatic logic [8:0] exp_read();
    logic [7:0] v;
    if (cur_m == 4'b1100) v = lock_m ? 8'hFF : mem_m[addr_m];
    else if (addr_m == 0) v = 8'h1E;
    else if (addr_m == 1) v = 8'h21;
    else v = 8'hFF;
    return {1'b1, v};
  endfunction

  // Drive a prog_n pulse and measure the busy window that follows.
  task automatic prog_busy(input logic with_xtal, output logic early, output int low);
    if (with_xtal) begin
      xtal1 = 1'b1;
      if (cur_lvl != 2'd0) addr_m = (addr_m + 1) % MB;
    end
    prog_n = 1'b0;
    tick(3);
    early = rdy;
    tick(1);
    low = 0;
    while (rdy === 1'b0 && low < WC + 50) begin
      low++;
      if (low == 4) xtal1 = 1'b0;
      if (low == 44) prog_n = 1'b1;
      tick(1);
    end
    xtal1 = 1'b0;
    prog_n = 1'b1;
    tick(4);
  endtask

  // Hold prog_n low in erase mode until the sweep starts and finishes.
  task automatic do_erase(output int start_cnt, output int low);
    prog_n = 1'b0;
    start_cnt = 0;
    while (rdy === 1'b1 && start_cnt < EM + 100) begin
      tick(1);
      start_cnt++;
    end
    low = 0;
    while (rdy === 1'b0 && low < MB + 50) begin
      low++;
      tick(1);
    end
    prog_n = 1'b1;
    tick(4);
    for (int i = 0; i < MB; i++) mem_m[i] = 8'hFF;
    lock_m = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++; if (p1_out !== 8'h00) begin bad++; $display("FAIL reset_p1_out: got %h want 00", p1_out); end
    total++; if (p1_oe !== 1'b0) begin bad++; $display("FAIL reset_p1_oe: got %b want 0", p1_oe); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    total++; if (lock1 !== 1'b0) begin bad++; $display("FAIL reset_lock1: got %b want 0", lock1); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_read_pulses();
    set_pins(2'd1, 4'b1100);
    exp_q.push_back(exp_read());
    want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
    if (got !== want) begin bad++; $display("FAIL read_addr0: got %h want %h", got, want); end
    for (int i = 1; i <= 3; i++) begin
      pulse_x();
      exp_q.push_back(exp_read());
      want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
      if (got !== want) begin bad++; $display("FAIL read_pulse%0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_write();
    logic early;
    int   low;
    logic [7:0] pat [2];
    pat[0] = 8'hA5;
    pat[1] = 8'h5A;
    for (int k = 0; k < 2; k++) begin
      p1_in = pat[k];
      set_pins(2'd2, 4'b1110);
      mem_m[addr_m] = mem_m[addr_m] & p1_in;
      prog_busy(1'b0, early, low);
      total++; if (early !== 1'b1) begin bad++; $display("FAIL write_rdy_early%0d: got %b want 1", k, early); end
      total++; if (low != WC) begin bad++; $display("FAIL write_busy_len%0d: got %0d want %0d", k, low, WC); end
      set_pins(2'd2, 4'b1100);
      exp_q.push_back(exp_read());
      want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
      if (got !== want) begin bad++; $display("FAIL write_readback%0d: got %h want %h", k, got, want); end
    end
    // Re-walk from address 0 to confirm the writes landed at address 3.
    set_pins(2'd0, 4'b1100);
    set_pins(2'd2, 4'b1100);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_read());
      want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
      if (got !== want) begin bad++; $display("FAIL write_walk%0d: got %h want %h", i, got, want); end
      if (i < 3) pulse_x();
    end
  endtask

  task automatic test_sigread();
    set_pins(2'd0, 4'b1100);
    total++; if (p1_oe !== 1'b0) begin bad++; $display("FAIL oe_level0: got %b want 0", p1_oe); end
    set_pins(2'd1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_read());
      want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
      if (got !== want) begin bad++; $display("FAIL sigread%0d: got %h want %h", i, got, want); end
      pulse_x();
    end
  endtask

  task automatic test_erase();
    int bsy;
    int start_cnt;
    int low;
    // Go back to address 3 which holds 8'h00.
    set_pins(2'd0, 4'b1100);
    set_pins(2'd2, 4'b1100);
    repeat (3) pulse_x();
    set_pins(2'd2, 4'b0001);
    prog_n = 1'b0;
    bsy = 0;
    for (int i = 0; i < EM / 2; i++) begin
      tick(1);
      if (rdy !== 1'b1) bsy++;
    end
    prog_n = 1'b1;
    tick(6);
    total++; if (bsy != 0) begin bad++; $display("FAIL erase_short_rdy: got %0d busy cycles want 0", bsy); end
    set_pins(2'd2, 4'b1100);
    exp_q.push_back(exp_read());
    want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
    if (got !== want) begin bad++; $display("FAIL erase_short_data: got %h want %h", got, want); end
    set_pins(2'd2, 4'b0001);
    do_erase(start_cnt, low);
    total++; if (start_cnt < EM || start_cnt > EM + 8) begin bad++; $display("FAIL erase_start: got %0d want %0d..%0d", start_cnt, EM, EM + 8); end
    total++; if (low != MB) begin bad++; $display("FAIL erase_busy_len: got %0d want %0d", low, MB); end
    set_pins(2'd0, 4'b1100);
    set_pins(2'd2, 4'b1100);
    for (int i = 0; i < MB; i++) begin
      exp_q.push_back(exp_read());
      want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
      if (got !== want) begin bad++; $display("FAIL erase_byte%0d: got %h want %h", i, got, want); end
      pulse_x();
    end
  endtask

  task automatic test_lock();
    logic early;
    int   low;
    int   start_cnt;
    set_pins(2'd2, 4'b1111);
    lock_m = 1'b1;
    prog_busy(1'b0, early, low);
    total++; if (low != WC) begin bad++; $display("FAIL lockw_busy_len: got %0d want %0d", low, WC); end
    total++; if (lock1 !== lock_m) begin bad++; $display("FAIL lockw_lock1: got %b want %b", lock1, lock_m); end
    p1_in = 8'h00;
    set_pins(2'd2, 4'b1110);
    prog_busy(1'b0, early, low);
    total++; if (low != WC) begin bad++; $display("FAIL locked_write_busy: got %0d want %0d", low, WC); end
    set_pins(2'd2, 4'b1100);
    exp_q.push_back(exp_read());
    want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
    if (got !== want) begin bad++; $display("FAIL locked_read: got %h want %h", got, want); end
    set_pins(2'd2, 4'b0001);
    do_erase(start_cnt, low);
    total++; if (low != MB) begin bad++; $display("FAIL lock_erase_len: got %0d want %0d", low, MB); end
    total++; if (lock1 !== lock_m) begin bad++; $display("FAIL unlock_lock1: got %b want %b", lock1, lock_m); end
  endtask

  task automatic test_wrap();
    logic early;
    int   low;
    set_pins(2'd0, 4'b1100);
    p1_in = 8'h3C;
    set_pins(2'd2, 4'b1110);
    mem_m[addr_m] = mem_m[addr_m] & p1_in;
    prog_busy(1'b0, early, low);
    total++; if (low != WC) begin bad++; $display("FAIL wrap_write_len: got %0d want %0d", low, WC); end
    set_pins(2'd2, 4'b1100);
    exp_q.push_back(exp_read());
    repeat (MB) pulse_x();
    want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
    if (got !== want) begin bad++; $display("FAIL wrap_addr0: got %h want %h", got, want); end
    pulse_x();
    exp_q.push_back(exp_read());
    want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
    if (got !== want) begin bad++; $display("FAIL wrap_addr1: got %h want %h", got, want); end
  endtask

  task automatic test_back_to_back();
    logic early;
    int   low;
    // xtal1 rise and prog_n fall together: write at the old address.
    p1_in = 8'h81;
    set_pins(2'd2, 4'b1110);
    mem_m[addr_m] = mem_m[addr_m] & p1_in;
    prog_busy(1'b1, early, low);
    total++; if (low != WC) begin bad++; $display("FAIL same_cycle_busy: got %0d want %0d", low, WC); end
    set_pins(2'd2, 4'b1100);
    exp_q.push_back(exp_read());
    want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
    if (got !== want) begin bad++; $display("FAIL same_cycle_next: got %h want %h", got, want); end
    set_pins(2'd0, 4'b1100);
    set_pins(2'd2, 4'b1100);
    pulse_x();
    exp_q.push_back(exp_read());
    want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
    if (got !== want) begin bad++; $display("FAIL same_cycle_data: got %h want %h", got, want); end
  endtask

  task automatic test_reset_mid_write();
    p1_in = 8'hF0;
    set_pins(2'd2, 4'b1110);
    mem_m[addr_m] = mem_m[addr_m] & p1_in;
    prog_n = 1'b0;
    tick(4);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rst_pre_busy: got %b want 0", rdy); end
    rst_n = 1'b0;
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rst_mid_rdy: got %b want 1", rdy); end
    total++; if (p1_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_oe: got %b want 0", p1_oe); end
    tick(2);
    rst_n = 1'b1;
    prog_n = 1'b1;
    addr_m = 0;
    tick(4);
    set_pins(2'd2, 4'b1100);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_read());
      want = exp_q.pop_front(); got = {p1_oe, p1_out}; total++;
      if (got !== want) begin bad++; $display("FAIL rst_after_read%0d: got %h want %h", i, got, want); end
      pulse_x();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    rst_level = 2'd0;
    xtal1 = 1'b0;
    prog_n = 1'b1;
    {p37, p35, p34, p33} = 4'b0000;
    p1_in = 8'hFF;
    addr_m = 0;
    lock_m = 1'b0;
    cur_lvl = 2'd0;
    cur_m = 4'b0000;
    for (int i = 0; i < MB; i++) mem_m[i] = 8'hFF;
    test_reset();
    test_read_pulses();
    test_write();
    test_sigread();
    test_erase();
    test_lock();
    test_wrap();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
